// File: rtl/snake_pkg.sv
// Shared definitions for the snake renderer: VGA 640x480 timing, board geometry,
// palette and the packed {row, col} cell layout used by every snake segment.
package snake_pkg;

    localparam logic [9:0] H_VISIBLE    = 10'd640;
    localparam logic [9:0] H_FRONT      = 10'd16;
    localparam logic [9:0] H_SYNC       = 10'd96;
    localparam logic [9:0] H_BACK       = 10'd48;
    localparam logic [9:0] H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam logic [9:0] H_LAST       = H_TOTAL - 10'd1;
    localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;

    localparam logic [9:0] V_VISIBLE    = 10'd480;
    localparam logic [9:0] V_FRONT      = 10'd10;
    localparam logic [9:0] V_SYNC       = 10'd2;
    localparam logic [9:0] V_BACK       = 10'd33;
    localparam logic [9:0] V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [9:0] V_LAST       = V_TOTAL - 10'd1;
    localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

    // Board is 16x16 cells of 30 px, horizontally centred in the visible area
    localparam logic [4:0] CELL_PX      = 5'd30;
    localparam logic [4:0] CELL_LAST    = CELL_PX - 5'd1;
    localparam logic [9:0] BOARD_X0     = 10'd80;
    localparam logic [9:0] BOARD_X_PRE  = BOARD_X0 - 10'd1;
    localparam logic [9:0] BOARD_X_END  = BOARD_X0 + 10'd480;
    localparam logic [9:0] BOARD_Y_END  = 10'd480;

    localparam logic [9:0] SNAP_X       = 10'd0;
    localparam logic [9:0] SNAP_Y       = V_VISIBLE;

    localparam logic [7:0] COL_HEAD     = 8'hFC;
    localparam logic [7:0] COL_BODY     = 8'h1C;
    localparam logic [7:0] COL_FOOD     = 8'hE0;
    localparam logic [7:0] COL_WIN      = 8'h08;
    localparam logic [7:0] COL_LOSE     = 8'h40;
    localparam logic [7:0] COL_BG       = 8'h00;
    localparam logic [7:0] COL_OFF      = 8'h02;
    localparam logic [7:0] COL_BLANK    = 8'h00;

    localparam int SEG_N = 16;
    localparam int LOC_W = SEG_N * 8;

    typedef struct packed {
        logic [3:0] row;
        logic [3:0] col;
    } cell_t;

    // Segment k sits in the top-down byte k of the flat vector; segment 0 is the head
    function automatic cell_t segment_cell(input logic [LOC_W-1:0] flat, input int k);
        return cell_t'(flat[LOC_W-1-8*k -: 8]);
    endfunction

endpackage

// File: rtl/vga_timing.sv
// 640x480 raster counters advancing on the pixel strobe, with raw sync and
// visible-area flags decoded from the current counter values.
module vga_timing
    import snake_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Pix_En,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic       hsync_raw,
    output logic       vsync_raw,
    output logic       visible_raw
);

    logic [9:0] x_reg;
    logic [9:0] y_reg;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            x_reg <= '0;
            y_reg <= '0;
        end else if (Pix_En) begin
            if (x_reg == H_LAST) begin
                x_reg <= '0;
                y_reg <= (y_reg == V_LAST) ? 10'd0 : y_reg + 10'd1;
            end else begin
                x_reg <= x_reg + 10'd1;
            end
        end
    end

    assign x_pos       = x_reg;
    assign y_pos       = y_reg;
    assign hsync_raw   = !((x_reg >= H_SYNC_START) && (x_reg < H_SYNC_END));
    assign vsync_raw   = !((y_reg >= V_SYNC_START) && (y_reg < V_SYNC_END));
    assign visible_raw = (x_reg < H_VISIBLE) && (y_reg < V_VISIBLE);

endmodule

// File: rtl/snake_render.sv
// Snake game VGA renderer: snapshots game state once per frame during vertical
// blank and draws it through a two-stage pixel pipeline with aligned sync.
module snake_render
    import snake_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Pix_En,
    input  logic [LOC_W-1:0] Locations_Flat,
    input  logic [3:0]       Length,
    input  logic [7:0]       Food,
    input  logic             Qw,
    input  logic             Ql,
    output logic             Hsync,
    output logic             Vsync,
    output logic [7:0]       Rgb,
    output logic             Frame_Start
);

    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic       hsync_raw;
    logic       vsync_raw;
    logic       visible_raw;

    vga_timing u_timing (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Pix_En      (Pix_En),
        .x_pos       (x_pos),
        .y_pos       (y_pos),
        .hsync_raw   (hsync_raw),
        .vsync_raw   (vsync_raw),
        .visible_raw (visible_raw)
    );

    logic snap_hit;
    assign snap_hit    = Pix_En && (x_pos == SNAP_X) && (y_pos == SNAP_Y);
    assign Frame_Start = snap_hit;

    logic [LOC_W-1:0] loc_shadow_reg;
    logic [3:0]       len_shadow_reg;
    cell_t            food_shadow_reg;
    logic             qw_shadow_reg;
    logic             ql_shadow_reg;
    logic             armed_reg;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            loc_shadow_reg  <= '0;
            len_shadow_reg  <= '0;
            food_shadow_reg <= '0;
            qw_shadow_reg   <= 1'b0;
            ql_shadow_reg   <= 1'b0;
            armed_reg       <= 1'b0;
        end else if (snap_hit) begin
            loc_shadow_reg  <= Locations_Flat;
            len_shadow_reg  <= Length;
            food_shadow_reg <= cell_t'(Food);
            qw_shadow_reg   <= Qw;
            ql_shadow_reg   <= Ql;
            armed_reg       <= 1'b1;
        end
    end

    // Sub-cell counters track the pixel currently addressed by x_pos/y_pos,
    // so they are loaded with zero on the strobe just before x=80 and y=0.
    logic [4:0] sub_x_reg;
    logic [3:0] col_reg;
    logic [4:0] sub_y_reg;
    logic [3:0] row_reg;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sub_x_reg <= '0;
            col_reg   <= '0;
            sub_y_reg <= '0;
            row_reg   <= '0;
        end else if (Pix_En) begin
            if (x_pos == BOARD_X_PRE) begin
                sub_x_reg <= '0;
                col_reg   <= '0;
            end else if (sub_x_reg == CELL_LAST) begin
                sub_x_reg <= '0;
                col_reg   <= col_reg + 4'd1;
            end else begin
                sub_x_reg <= sub_x_reg + 5'd1;
            end

            if (x_pos == H_LAST) begin
                if (y_pos == V_LAST) begin
                    sub_y_reg <= '0;
                    row_reg   <= '0;
                end else if (sub_y_reg == CELL_LAST) begin
                    sub_y_reg <= '0;
                    row_reg   <= row_reg + 4'd1;
                end else begin
                    sub_y_reg <= sub_y_reg + 5'd1;
                end
            end
        end
    end

    // Stage 1: cell address and area flags
    cell_t s1_cell_reg;
    logic  s1_board_reg;
    logic  s1_visible_reg;
    logic  s1_hsync_reg;
    logic  s1_vsync_reg;
    logic  in_board;

    assign in_board = (x_pos >= BOARD_X0) && (x_pos < BOARD_X_END) && (y_pos < BOARD_Y_END);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_cell_reg    <= '0;
            s1_board_reg   <= 1'b0;
            s1_visible_reg <= 1'b0;
            s1_hsync_reg   <= 1'b1;
            s1_vsync_reg   <= 1'b1;
        end else if (Pix_En) begin
            s1_cell_reg    <= '{row: row_reg, col: col_reg};
            s1_board_reg   <= in_board;
            s1_visible_reg <= visible_raw;
            s1_hsync_reg   <= hsync_raw;
            s1_vsync_reg   <= vsync_raw;
        end
    end

    // Stage 2: 16-way segment compare and colour priority
    logic [SEG_N-1:0] seg_hit;

    genvar gi;
    generate
        for (gi = 0; gi < SEG_N; gi++) begin : g_seg
            assign seg_hit[gi] = (segment_cell(loc_shadow_reg, gi) == s1_cell_reg)
                                 && (4'(gi) <= len_shadow_reg);
        end
    endgenerate

    logic [7:0] rgb_next;

    always_comb begin
        rgb_next = COL_BLANK;
        if (armed_reg && s1_visible_reg) begin
            if (!s1_board_reg)                       rgb_next = COL_OFF;
            else if (seg_hit[0])                     rgb_next = COL_HEAD;
            else if (|seg_hit[SEG_N-1:1])            rgb_next = COL_BODY;
            else if (food_shadow_reg == s1_cell_reg) rgb_next = COL_FOOD;
            else if (qw_shadow_reg)                  rgb_next = COL_WIN;
            else if (ql_shadow_reg)                  rgb_next = COL_LOSE;
            else                                     rgb_next = COL_BG;
        end
    end

    logic [7:0] rgb_reg;
    logic       hsync_reg;
    logic       vsync_reg;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rgb_reg   <= COL_BLANK;
            hsync_reg <= 1'b1;
            vsync_reg <= 1'b1;
        end else if (Pix_En) begin
            rgb_reg   <= rgb_next;
            hsync_reg <= s1_hsync_reg;
            vsync_reg <= s1_vsync_reg;
        end
    end

    assign Rgb   = rgb_reg;
    assign Hsync = hsync_reg;
    assign Vsync = vsync_reg;

endmodule

// File: tb/tb_snake_render.sv
// Directed bench for snake_render: raster position model, per-pixel colour
// vectors over several frames, plus reset, timing and snapshot sequences.
module tb_snake_render;

    logic         Clk = 1'b0;
    logic         rst_n;
    logic         pix_en;
    logic [127:0] loc;
    logic [3:0]   len;
    logic [7:0]   food;
    logic         qw;
    logic         ql;
    logic         Hsync;
    logic         Vsync;
    logic [7:0]   Rgb;
    logic         Frame_Start;

    always #5 Clk = ~Clk;

    snake_render dut (
        .Clk            (Clk),
        .Reset_n        (rst_n),
        .Pix_En         (pix_en),
        .Locations_Flat (loc),
        .Length         (len),
        .Food           (food),
        .Qw             (qw),
        .Ql             (ql),
        .Hsync          (Hsync),
        .Vsync          (Vsync),
        .Rgb            (Rgb),
        .Frame_Start    (Frame_Start)
    );

    typedef struct {
        logic [127:0] loc;
        logic [3:0]   len;
        logic [7:0]   food;
        logic         qw;
        logic         ql;
    } cfg_t;

    typedef struct {
        int         frame;
        int         x;
        int         y;
        logic [7:0] exp;
    } pix_vec_t;

    cfg_t     cfgs [5];
    pix_vec_t vecs [40];
    int       nv;

    int n_checks = 0;
    int n_pass   = 0;

    // Position model: pos is what the counters hold now, h2 is the pixel at the outputs
    int pos_x = 0, pos_y = 0, h1x = 0, h1y = 0, h2x = 0, h2y = 0;
    int n_ticks = 0, sync_errs = 0, fs_errs = 0, fs_cnt = 0;
    int hs_low = 0, vs_low = 0, nz_cnt = 0;
    bit nz_en = 0;
    int snap_tick [5];
    int snap_vs   [5];
    int snap_fs   [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        logic pe;
        logic exp_hs, exp_vs, exp_fs;
        pe = pix_en;
        @(posedge Clk);
        #1;
        n_ticks++;
        if (!rst_n) begin
            pos_x = 0; pos_y = 0; h1x = 0; h1y = 0; h2x = 0; h2y = 0;
        end else if (pe) begin
            h2x = h1x; h2y = h1y; h1x = pos_x; h1y = pos_y;
            if (pos_x == 799) begin
                pos_x = 0;
                pos_y = (pos_y == 524) ? 0 : pos_y + 1;
            end else begin
                pos_x++;
            end
        end
        exp_hs = !(h2x >= 656 && h2x < 752);
        exp_vs = !(h2y >= 490 && h2y < 492);
        exp_fs = rst_n && pix_en && pos_x == 0 && pos_y == 480;
        if (Hsync !== exp_hs || Vsync !== exp_vs) sync_errs++;
        if (Frame_Start !== exp_fs) fs_errs++;
        if (Frame_Start === 1'b1) fs_cnt++;
        if (Hsync === 1'b0) hs_low++;
        if (Vsync === 1'b0) vs_low++;
        if (nz_en && Rgb !== 8'h00) nz_cnt++;
    endtask

    task automatic wait_pos(input int x, input int y);
        int guard;
        guard = 0;
        while (!(pos_x == x && pos_y == y) && guard < 900000) begin
            tick();
            guard++;
        end
        if (guard >= 900000) begin
            n_checks++;
            $display("FAIL wait_pos(%0d,%0d): timeout at (%0d,%0d)", x, y, pos_x, pos_y);
        end
    endtask

    task automatic wait_out(input int x, input int y);
        int guard;
        guard = 0;
        while (!(h2x == x && h2y == y) && guard < 900000) begin
            tick();
            guard++;
        end
        if (guard >= 900000) begin
            n_checks++;
            $display("FAIL wait_out(%0d,%0d): timeout", x, y);
        end
    endtask

    task automatic apply_cfg(input cfg_t c);
        loc  = c.loc;
        len  = c.len;
        food = c.food;
        qw   = c.qw;
        ql   = c.ql;
    endtask

    function automatic logic [127:0] make_loc(input int mode);
        logic [127:0] v;
        v = '0;
        for (int k = 0; k < 16; k++) begin
            if (mode == 2) v[127-8*k -: 8] = {k[3:0], k[3:0]};
            else           v[127-8*k -: 8] = 8'hEE;
        end
        if (mode == 2) begin
            v[127-8*3 -: 8] = 8'h00;
        end else begin
            v[127 -: 8]       = 8'h00;
            v[127-8 -: 8]     = 8'h11;
            if (mode == 1) v[127-16 -: 8] = 8'h23;
        end
        return v;
    endfunction

    task automatic add_vec(input int f, input int x, input int y, input logic [7:0] e);
        vecs[nv] = '{frame: f, x: x, y: y, exp: e};
        nv++;
    endtask

    task automatic snapshot_step(input int f);
        wait_pos(0, 480);
        snap_tick[f] = n_ticks;
        snap_vs[f]   = vs_low;
        snap_fs[f]   = fs_cnt;
        check($sformatf("frame_start_f%0d", f), Frame_Start, 1);
        tick();
        check($sformatf("frame_start_drop_f%0d", f), Frame_Start, 0);
    endtask

    initial begin
        int  h0, t0, vi;
        bit  changed;

        cfgs[0] = '{loc: make_loc(0), len: 4'd0,  food: 8'hFF, qw: 1'b0, ql: 1'b0};
        cfgs[1] = '{loc: make_loc(1), len: 4'd2,  food: 8'h23, qw: 1'b0, ql: 1'b1};
        cfgs[2] = '{loc: make_loc(2), len: 4'd15, food: 8'h0F, qw: 1'b1, ql: 1'b1};
        cfgs[3] = '{loc: make_loc(0), len: 4'd0,  food: 8'h22, qw: 1'b0, ql: 1'b0};
        cfgs[4] = '{loc: make_loc(0), len: 4'd0,  food: 8'h33, qw: 1'b1, ql: 1'b0};

        nv = 0;
        add_vec(1,  79,   0, 8'h02); add_vec(1,  80,   0, 8'hFC);
        add_vec(1, 109,   0, 8'hFC); add_vec(1, 110,   0, 8'h00);
        add_vec(1, 639,  10, 8'h02); add_vec(1, 640,  10, 8'h00);
        add_vec(1, 109,  29, 8'hFC); add_vec(1, 125,  45, 8'h00);
        add_vec(1, 505, 425, 8'h00); add_vec(1, 559, 479, 8'hE0);
        add_vec(1, 560, 479, 8'h02);
        add_vec(2,  80,   0, 8'hFC); add_vec(2, 110,   0, 8'h40);
        add_vec(2, 125,  45, 8'h1C); add_vec(2, 185,  75, 8'h1C);
        add_vec(2,  79, 100, 8'h02); add_vec(2, 600, 300, 8'h02);
        add_vec(2, 505, 425, 8'h40);
        add_vec(3,  80,   0, 8'hFC); add_vec(3, 540,   5, 8'hE0);
        add_vec(3, 125,  45, 8'h1C); add_vec(3,  95,  95, 8'h08);
        add_vec(3, 185, 105, 8'h08); add_vec(3, 245, 165, 8'h1C);
        add_vec(3, 300, 300, 8'h08); add_vec(3, 559, 479, 8'h1C);
        add_vec(4,  80,   0, 8'hFC); add_vec(4, 155,  75, 8'hE0);
        add_vec(4, 185, 110, 8'h00); add_vec(4, 300, 300, 8'h00);
        add_vec(5,  80,   0, 8'hFC); add_vec(5, 155,  75, 8'h08);
        add_vec(5, 185, 110, 8'hE0);

        rst_n  = 1'b0;
        pix_en = 1'b1;
        apply_cfg(cfgs[0]);
        repeat (3) tick();
        check("reset_hsync", Hsync, 1);
        check("reset_vsync", Vsync, 1);
        check("reset_rgb", Rgb, 0);
        check("reset_frame_start", Frame_Start, 0);
        rst_n = 1'b1;

        // Frame 0: nothing drawn before the first snapshot
        nz_cnt = 0;
        nz_en  = 1;
        wait_pos(0, 10);
        h0 = hs_low;
        repeat (800) tick();
        check("hsync_low_per_line", hs_low - h0, 96);
        wait_pos(0, 480);
        nz_en = 0;
        check("first_frame_blank", nz_cnt, 0);
        snapshot_step(0);
        apply_cfg(cfgs[1]);

        vi      = 0;
        changed = 0;
        for (int f = 1; f <= 5; f++) begin
            if (f == 3) begin
                for (int i = 0; i < 40; i++) begin
                    pix_en = 1'($urandom_range(0, 1));
                    tick();
                end
                pix_en = 1'b1;
            end
            while (vi < nv && vecs[vi].frame == f) begin
                if (f == 4 && !changed && vecs[vi].y > 100) begin
                    wait_pos(0, 100);
                    apply_cfg(cfgs[4]);
                    changed = 1;
                end
                wait_out(vecs[vi].x, vecs[vi].y);
                check($sformatf("pix%0d f%0d (%0d,%0d) rgb", vi, f, vecs[vi].x, vecs[vi].y),
                      Rgb, vecs[vi].exp);
                vi++;
            end
            if (f < 5) begin
                snapshot_step(f);
                if (f < 3) apply_cfg(cfgs[f+1]);
            end
        end

        check("frame_period_cycles", snap_tick[2] - snap_tick[1], 420000);
        check("vsync_low_per_frame", snap_vs[2] - snap_vs[1], 1600);
        check("frame_start_per_frame", snap_fs[2] - snap_fs[1], 1);

        // Mid-frame reset restarts the raster at (0,0) and blanks until the next snapshot
        wait_pos(300, 200);
        rst_n = 1'b0;
        #1;
        check("midreset_hsync", Hsync, 1);
        check("midreset_vsync", Vsync, 1);
        check("midreset_rgb", Rgb, 0);
        check("midreset_frame_start", Frame_Start, 0);
        repeat (2) tick();
        rst_n  = 1'b1;
        t0     = n_ticks;
        nz_cnt = 0;
        nz_en  = 1;
        wait_pos(0, 480);
        nz_en = 0;
        check("restart_to_snapshot_cycles", n_ticks - t0, 384000);
        check("post_reset_frame_blank", nz_cnt, 0);
        check("post_reset_frame_start", Frame_Start, 1);

        check("sync_model_errs", sync_errs, 0);
        check("frame_start_model_errs", fs_errs, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
